// File: rtl/alu_4bit.sv
// Registered 4-bit ALU built on a ripple chain of four full adders.
// Result and flags are captured one clock after the inputs are presented.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] opcode,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       of
);

  localparam logic [3:0] OP_NAND = 4'b0000;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADDC = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AVG  = 4'b1111;

  logic [3:0] chain_b;
  logic [3:0] chain_s;
  logic [4:0] carry;

  logic [3:0] s_d, s_q;
  logic       cout_d, cout_q;
  logic       of_d, of_q;

  // SUB reuses the adder as a + ~b + 1; AVG and ADD run the chain with carry-in 0.
  always_comb begin
    chain_b  = b;
    carry[0] = 1'b0;
    case (opcode)
      OP_ADDC: carry[0] = cin;
      OP_SUB: begin
        chain_b  = ~b;
        carry[0] = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_rca
    full_adder u_fa (
      .a  (a[i]),
      .b  (chain_b[i]),
      .ci (carry[i]),
      .s  (chain_s[i]),
      .co (carry[i+1])
    );
  end

  always_comb begin
    s_d    = '0;
    cout_d = 1'b0;
    of_d   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC, OP_SUB: begin
        s_d    = chain_s;
        cout_d = carry[4];
        of_d   = carry[3] ^ carry[4];
      end
      OP_NAND: s_d = ~(a & b);
      OP_NOR:  s_d = ~(a | b);
      OP_XOR:  s_d = a ^ b;
      OP_NOT:  s_d = ~a;
      OP_SRL: begin
        s_d    = {1'b0, a[3:1]};
        cout_d = a[0];
      end
      // Halving keeps the 5th sum bit as the new MSB.
      OP_AVG:  s_d = {carry[4], chain_s[3:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      of_q   <= of_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign of   = of_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed-vector bench for alu_4bit: table of opcodes plus reset and latency sequences.

module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, opcode;
  logic       cin;
  logic [3:0] s;
  logic       cout, of;

  int errors = 0;
  int checks = 0;

  alu_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .of     (of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       of;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic check_out(input string name, input logic [3:0] es,
                           input logic ec, input logic eo);
    checks++;
    if (s !== es || cout !== ec || of !== eo) begin
      errors++;
      $display("FAIL %s: got s=%b cout=%b of=%b, expected s=%b cout=%b of=%b",
               name, s, cout, of, es, ec, eo);
    end
  endtask

  task automatic apply(input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] iop, input logic ic);
    @(negedge clk);
    a = ia; b = ib; opcode = iop; cin = ic;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        a       b       op      cin   s       cout  of
    vt[0]  = '{4'h6, 4'h3, 4'b1000, 1'b0, 4'h9, 1'b0, 1'b1}; // ADD
    vt[1]  = '{4'h7, 4'h5, 4'b1001, 1'b1, 4'hD, 1'b0, 1'b1}; // ADDC
    vt[2]  = '{4'h7, 4'h5, 4'b1010, 1'b0, 4'h2, 1'b1, 1'b0}; // SUB
    vt[3]  = '{4'h0, 4'h1, 4'b1010, 1'b0, 4'hF, 1'b0, 1'b0}; // SUB borrow
    vt[4]  = '{4'h6, 4'hF, 4'b0000, 1'b0, 4'h9, 1'b0, 1'b0}; // NAND
    vt[5]  = '{4'h6, 4'h1, 4'b0001, 1'b0, 4'h8, 1'b0, 1'b0}; // NOR
    vt[6]  = '{4'h5, 4'hF, 4'b0010, 1'b0, 4'hA, 1'b0, 1'b0}; // XOR
    vt[7]  = '{4'hD, 4'h7, 4'b0100, 1'b0, 4'h2, 1'b0, 1'b0}; // NOT
    vt[8]  = '{4'h5, 4'h0, 4'b0101, 1'b0, 4'h2, 1'b1, 1'b0}; // SRL
    vt[9]  = '{4'h6, 4'h3, 4'b1111, 1'b0, 4'h4, 1'b0, 1'b0}; // AVG
    vt[10] = '{4'h6, 4'h3, 4'b0011, 1'b1, 4'h0, 1'b0, 1'b0}; // unused
    vt[11] = '{4'hF, 4'h1, 4'b1000, 1'b0, 4'h0, 1'b1, 1'b0}; // ADD wrap
    vt[12] = '{4'h8, 4'h1, 4'b1010, 1'b0, 4'h7, 1'b1, 1'b1}; // SUB -8-1
    vt[13] = '{4'h4, 4'h4, 4'b1000, 1'b0, 4'h8, 1'b0, 1'b1}; // ADD 4+4
    vt[14] = '{4'h1, 4'h1, 4'b1000, 1'b1, 4'h2, 1'b0, 1'b0}; // ADD ignores cin
    vt[15] = '{4'hE, 4'h0, 4'b0101, 1'b0, 4'h7, 1'b0, 1'b0}; // SRL even
    vt[16] = '{4'hF, 4'hF, 4'b1111, 1'b1, 4'hF, 1'b0, 1'b0}; // AVG carry kept
    vt[17] = '{4'hF, 4'hF, 4'b0110, 1'b1, 4'h0, 1'b0, 1'b0}; // unused
    vt[18] = '{4'hF, 4'hF, 4'b1110, 1'b1, 4'h0, 1'b0, 1'b0}; // unused
    vt[19] = '{4'h3, 4'h3, 4'b1010, 1'b1, 4'h0, 1'b1, 1'b0}; // SUB ignores cin

    rst = 1'b1; a = '0; b = '0; opcode = '0; cin = 1'b0;
    #12;
    check_out("reset_state", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].a, vt[i].b, vt[i].op, vt[i].cin);
      check_out($sformatf("vec%0d", i), vt[i].s, vt[i].cout, vt[i].of);
    end

    // Full-adder truth table through bit 0 of ADDC; bit 1 carries the co.
    for (int j = 0; j < 8; j++) begin
      logic fa, fb, fc;
      logic [1:0] tot;
      fa = j[2]; fb = j[1]; fc = j[0];
      tot = 2'(fa) + 2'(fb) + 2'(fc);
      apply({3'b000, fa}, {3'b000, fb}, 4'b1001, fc);
      check_out($sformatf("fa%0d", j), {2'b00, tot}, 1'b0, 1'b0);
    end

    // Latency: new inputs must not show until the next rising edge.
    apply(4'h6, 4'h3, 4'b1000, 1'b0);
    @(negedge clk);
    a = 4'h7; b = 4'h5; opcode = 4'b1010;
    #2;
    check_out("latency_hold", 4'h9, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_out("latency_update", 4'h2, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a nonzero result.
    apply(4'hD, 4'h0, 4'b0100, 1'b0);
    check_out("pre_reset", 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 4'h0, 1'b0, 1'b0);
    a = 4'h6; b = 4'h3; opcode = 4'b1000;
    @(posedge clk);
    #1;
    check_out("reset_held", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("after_release", 4'h9, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
